// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART transmitter: state encodings, default widths
// and parity-type codes.
package uart_tx_pkg;

   localparam int unsigned DEF_DATA_WIDTH     = 8;
   localparam int unsigned DEF_PRESCALE_WIDTH = 6;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   typedef logic [2:0] state_t;

   localparam state_t IDLE   = 3'd0;
   localparam state_t START  = 3'd1;
   localparam state_t DATA   = 3'd2;
   localparam state_t PARITY = 3'd3;
   localparam state_t STOP   = 3'd4;

endpackage

// File: rtl/uart_tx_baud_cnt.sv
// Bit-period down-counter: load with the bit length in clocks, bit_tick is
// high on the last cycle of each period.
module uart_tx_baud_cnt #(
   parameter int unsigned PRESCALE_WIDTH = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load,
   input  logic [PRESCALE_WIDTH-1:0] load_val,
   output logic                      bit_tick
);

   logic [PRESCALE_WIDTH-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val - PRESCALE_WIDTH'(1);
      end else if (cnt != '0) begin
         cnt <= cnt - PRESCALE_WIDTH'(1);
      end
   end

   assign bit_tick = (cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, one stop.
// Define UART_TX_HOLD_EN to add a one-entry holding register and hold_full.
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int unsigned PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [DATA_WIDTH-1:0]     P_DATA,
   input  logic                      DATA_VALID,
   input  logic                      PAR_EN,
   input  logic                      PAR_TYP,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic                      TX_OUT,
   output logic                      busy
`ifdef UART_TX_HOLD_EN
   ,
   output logic                      hold_full
`endif
);

   localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   state_t                    state;
   logic [IDX_W-1:0]          bit_idx;
   logic [DATA_WIDTH-1:0]     shreg;
   logic                      par_bit;
   logic                      par_en_q;
   logic [PRESCALE_WIDTH-1:0] presc_q;
   logic [PRESCALE_WIDTH-1:0] presc_in_eff;

   logic                      bit_tick;
   logic                      frame_done;
   logic                      start;
   logic                      baud_load;
   logic [PRESCALE_WIDTH-1:0] baud_val;

   logic [DATA_WIDTH-1:0]     st_data;
   logic                      st_pe;
   logic                      st_pt;
   logic [PRESCALE_WIDTH-1:0] st_presc;

   assign presc_in_eff = (prescale == '0) ? PRESCALE_WIDTH'(1) : prescale;
   assign frame_done   = (state == STOP) && bit_tick;

`ifdef UART_TX_HOLD_EN
   logic [DATA_WIDTH-1:0]     hold_data;
   logic                      hold_pe;
   logic                      hold_pt;
   logic [PRESCALE_WIDTH-1:0] hold_presc;
   logic                      hold_load;
   logic                      start_hold;
   logic                      start_new;

   // A held byte starts straight from the last STOP cycle, or from IDLE if it
   // was captured on the very edge the previous frame finished.
   assign hold_load  = DATA_VALID && !hold_full && (state != IDLE);
   assign start_hold = hold_full && ((state == IDLE) || frame_done);
   assign start_new  = (state == IDLE) && !hold_full && DATA_VALID;
   assign start      = start_new || start_hold;

   assign st_data  = start_hold ? hold_data  : P_DATA;
   assign st_pe    = start_hold ? hold_pe    : PAR_EN;
   assign st_pt    = start_hold ? hold_pt    : PAR_TYP;
   assign st_presc = start_hold ? hold_presc : presc_in_eff;

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_full  <= 1'b0;
         hold_data  <= '0;
         hold_pe    <= 1'b0;
         hold_pt    <= 1'b0;
         hold_presc <= '0;
      end else if (hold_load) begin
         hold_full  <= 1'b1;
         hold_data  <= P_DATA;
         hold_pe    <= PAR_EN;
         hold_pt    <= PAR_TYP;
         hold_presc <= presc_in_eff;
      end else if (start_hold) begin
         hold_full  <= 1'b0;
      end
   end

   assign busy = (state != IDLE) || hold_full;
`else
   assign start    = (state == IDLE) && DATA_VALID;
   assign st_data  = P_DATA;
   assign st_pe    = PAR_EN;
   assign st_pt    = PAR_TYP;
   assign st_presc = presc_in_eff;
   assign busy     = (state != IDLE);
`endif

   assign baud_load = start || (bit_tick && (state != IDLE) && (state != STOP));
   assign baud_val  = start ? st_presc : presc_q;

   uart_tx_baud_cnt #(
      .PRESCALE_WIDTH (PRESCALE_WIDTH)
   ) u_baud_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (baud_load),
      .load_val (baud_val),
      .bit_tick (bit_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         bit_idx  <= '0;
         shreg    <= '0;
         par_bit  <= 1'b0;
         par_en_q <= 1'b0;
         presc_q  <= '0;
      end else if (start) begin
         state    <= START;
         bit_idx  <= '0;
         shreg    <= st_data;
         par_bit  <= (st_pt == PAR_ODD) ? ~(^st_data) : (^st_data);
         par_en_q <= st_pe;
         presc_q  <= st_presc;
      end else if (bit_tick) begin
         case (state)
            START: begin
               state   <= DATA;
               bit_idx <= '0;
            end
            DATA: begin
               if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
                  state <= par_en_q ? PARITY : STOP;
               end else begin
                  bit_idx <= bit_idx + IDX_W'(1);
                  shreg   <= shreg >> 1;
               end
            end
            PARITY:  state <= STOP;
            STOP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      TX_OUT = 1'b1;
      case (state)
         START:   TX_OUT = 1'b0;
         DATA:    TX_OUT = shreg[0];
         PARITY:  TX_OUT = par_bit;
         default: TX_OUT = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx; expected frames are hand-written
// constants, LSB-first with the start bit at index 0.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] P_DATA;
   logic       DATA_VALID;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic [5:0] prescale;
   logic       TX_OUT;
   logic       busy;
`ifdef UART_TX_HOLD_EN
   logic       hold_full;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_tx #(
      .DATA_WIDTH     (8),
      .PRESCALE_WIDTH (6)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .P_DATA     (P_DATA),
      .DATA_VALID (DATA_VALID),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .prescale   (prescale),
      .TX_OUT     (TX_OUT),
      .busy       (busy)
`ifdef UART_TX_HOLD_EN
      ,
      .hold_full  (hold_full)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drive a request for one cycle; returns just after the accept edge.
   task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic [5:0] ps);
      @(posedge clk); #1;
      P_DATA = d; PAR_EN = pe; PAR_TYP = pt; prescale = ps; DATA_VALID = 1'b1;
      @(posedge clk); #1;
      DATA_VALID = 1'b0;
   endtask

   // Every cycle of the frame: busy high and line equal to the expected bit.
   task automatic check_frame(input string tag, input logic [10:0] bits,
                              input int nbits, input int p);
      for (int b = 0; b < nbits; b++) begin
         for (int c = 0; c < p; c++) begin
            @(negedge clk);
            check(tag, {30'd0, busy, TX_OUT}, {30'd0, 1'b1, bits[b]});
         end
      end
   endtask

   task automatic check_idle(input string tag);
      @(negedge clk);
      check(tag, {30'd0, busy, TX_OUT}, 32'd1);
   endtask

   initial begin
      rst = 1'b1; P_DATA = '0; DATA_VALID = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
      prescale = 6'd8;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_line", {30'd0, busy, TX_OUT}, 32'd1);
`ifdef UART_TX_HOLD_EN
      check("reset_hold", {31'd0, hold_full}, 32'd0);
`endif
      rst = 1'b0;

      // 0xA5, no parity, 8 clocks/bit: 80 busy cycles then idle
      start_frame(8'hA5, 1'b0, 1'b0, 6'd8);
      check_frame("a5_frame", {1'b0, 1'b1, 8'hA5, 1'b0}, 10, 8);
      check_idle("a5_idle");

      // 0x55 even parity -> 0, odd parity -> 1
      start_frame(8'h55, 1'b1, 1'b0, 6'd8);
      check_frame("55_even", {1'b1, 1'b0, 8'h55, 1'b0}, 11, 8);
      check_idle("55_even_idle");
      start_frame(8'h55, 1'b1, 1'b1, 6'd3);
      check_frame("55_odd", {1'b1, 1'b1, 8'h55, 1'b0}, 11, 3);
      check_idle("55_odd_idle");

      // 0x07 even parity -> 1; inputs scrambled right after acceptance
      start_frame(8'h07, 1'b1, 1'b0, 6'd4);
      P_DATA = 8'hFF; PAR_EN = 1'b0; PAR_TYP = 1'b1; prescale = 6'd1;
      check_frame("07_latched", {1'b1, 1'b1, 8'h07, 1'b0}, 11, 4);
      check_idle("07_idle");

      // prescale 0 behaves as 1 clock per bit
      start_frame(8'h81, 1'b0, 1'b0, 6'd0);
      check_frame("presc0", {1'b0, 1'b1, 8'h81, 1'b0}, 10, 1);
      check_idle("presc0_idle");

`ifndef UART_TX_HOLD_EN
      // request during a frame is dropped
      start_frame(8'hC3, 1'b0, 1'b0, 6'd2);
      fork
         check_frame("c3_frame", {1'b0, 1'b1, 8'hC3, 1'b0}, 10, 2);
         begin
            repeat (5) @(posedge clk); #1;
            P_DATA = 8'h3C; DATA_VALID = 1'b1;
            @(posedge clk); #1;
            DATA_VALID = 1'b0;
         end
      join
      check_idle("c3_idle");
      check_idle("c3_no_second");

      // DATA_VALID held high: exactly one idle cycle between frames
      @(posedge clk); #1;
      P_DATA = 8'h00; PAR_EN = 1'b0; prescale = 6'd2; DATA_VALID = 1'b1;
      @(posedge clk); #1;
      check_frame("b2b_first", {1'b0, 1'b1, 8'h00, 1'b0}, 10, 2);
      check_idle("b2b_gap");
      @(posedge clk); #1;
      DATA_VALID = 1'b0;
      check_frame("b2b_second", {1'b0, 1'b1, 8'h00, 1'b0}, 10, 2);
      check_idle("b2b_idle");
`endif

      // reset during data bit 3 aborts the frame
      start_frame(8'hA5, 1'b0, 1'b0, 6'd4);
      repeat (18) @(negedge clk);
      check("rst_pre_bit3", {30'd0, busy, TX_OUT}, 32'd2);
      rst = 1'b1;
      @(negedge clk);
      check("rst_abort", {30'd0, busy, TX_OUT}, 32'd1);
      rst = 1'b0;
      check_idle("rst_idle");
      start_frame(8'h3C, 1'b1, 1'b1, 6'd2);
      check_frame("post_rst", {1'b1, 1'b1, 8'h3C, 1'b0}, 11, 2);
      check_idle("post_rst_idle");

`ifdef UART_TX_HOLD_EN
      // second byte held during the first frame; frames are contiguous
      start_frame(8'hA5, 1'b0, 1'b0, 6'd8);
      fork
         begin
            check_frame("hold_first", {1'b0, 1'b1, 8'hA5, 1'b0}, 10, 8);
            check_frame("hold_second", {1'b0, 1'b1, 8'h3C, 1'b0}, 10, 8);
         end
         begin
            repeat (5) @(posedge clk); #1;
            P_DATA = 8'h3C; PAR_EN = 1'b0; prescale = 6'd8; DATA_VALID = 1'b1;
            @(posedge clk); #1;
            DATA_VALID = 1'b0;
            @(negedge clk);
            check("hold_set", {31'd0, hold_full}, 32'd1);
            repeat (74) @(negedge clk);
            check("hold_clr", {31'd0, hold_full}, 32'd0);
         end
      join
      check_idle("hold_idle");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmit serializer that drives the serial line consumed by the receiver (its TX_OUT connects to the receiver's RX_IN).
- Accepts a parallel byte, then frames it LSB-first: start bit, optional even/odd parity bit, one stop bit.
- Each bit is held for `prescale` clock cycles, so frames match the receiver's bit period at the same `prescale` setting.
- Sits between the host/register interface and the physical TX pin.

Parameters:
- DATA_WIDTH, 8, payload bits per frame
- PRESCALE_WIDTH, 6, width of the bit-period count input

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- P_DATA  input  DATA_WIDTH  byte to transmit
- DATA_VALID  input  1  request to send P_DATA
- PAR_EN  input  1  1 = parity bit inserted
- PAR_TYP  input  1  0 = even parity, 1 = odd parity
- prescale  input  PRESCALE_WIDTH  clocks per bit; 0 treated as 1
- TX_OUT  output  1  serial line, idle high
- busy  output  1  frame in progress; DATA_VALID ignored while high (base build)

Behaviour:
- Reset values: TX_OUT=1, busy=0, FSM=IDLE, bit counter=0, prescale counter=0.
- Reset wins over any in-flight frame: at the next edge TX_OUT=1, busy=0, and any held byte is discarded.
- FSM states:
  - IDLE: TX_OUT=1, busy=0.
  - START: TX_OUT=0.
  - DATA: TX_OUT = data[bit_idx], bit_idx 0..DATA_WIDTH-1.
  - PARITY: TX_OUT = parity bit.
  - STOP: TX_OUT=1.
- Transitions:
  - IDLE→START when DATA_VALID=1 at a clk edge.
  - START→DATA after prescale cycles.
  - DATA advances bit_idx every prescale cycles; after bit DATA_WIDTH-1 it goes to PARITY if the latched PAR_EN=1, else to STOP.
  - PARITY→STOP after prescale cycles.
  - STOP→IDLE after prescale cycles.
- Latching at acceptance: P_DATA, PAR_EN, PAR_TYP and prescale are all captured at the accept edge. Changes during the frame have no effect.
- Latency:
  - TX_OUT goes low and busy goes high in the cycle after acceptance.
  - Each bit lasts exactly max(prescale,1) cycles.
  - busy stays high through the last STOP cycle and drops on the IDLE cycle.
- Parity bit:
  - Even: XOR of the latched data bits.
  - Odd: inverted XOR of the latched data bits.
- Frame length: (10 + PAR_EN) × prescale cycles.
- Back-to-back frames (base build): at least one IDLE cycle separates frames, so the line is high for prescale+1 cycles between frames.
- DATA_VALID asserted while busy=1 is dropped silently (base build).

Optional Feature:
- Macro: UART_TX_HOLD_EN.
- When defined:
  - A one-entry holding register accepts DATA_VALID while busy=1 if the register is empty.
  - It stores P_DATA, PAR_EN, PAR_TYP and prescale.
  - On the last STOP cycle, a held byte moves directly into START with no IDLE cycle, so frames are contiguous.
  - busy is high while a frame is active or a byte is held.
  - Output hold_full (1 bit) is added and reset to 0.
  - DATA_VALID while hold_full=1 is dropped.
- When undefined: no holding register, no hold_full port; base behaviour as above.

Decomposition:
- Package uart_tx_pkg holds:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP)
  - default DATA_WIDTH and PRESCALE_WIDTH constants
  - parity-type constants PAR_EVEN=0 and PAR_ODD=1
- Sub-module uart_tx_baud_cnt: prescale down-counter with a load input; it emits bit_tick on the last cycle of each bit period.
- FSM, shift register and parity logic stay in uart_tx.

Test Plan:
- 0xA5, PAR_EN=0, prescale=8 → TX_OUT = 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles; busy high exactly 80 cycles.
- 0x55, PAR_EN=1, PAR_TYP=0 → parity bit 0, frame 88 cycles. Same byte with PAR_TYP=1 → parity bit 1.
- 0x07, even parity, prescale=4 → parity bit 1. P_DATA changed to 0xFF mid-frame → transmitted data still 0x07.
- DATA_VALID pulsed with 0x3C during a frame (base build) → request ignored. Next accept begins one IDLE cycle after STOP ends.
- rst asserted in the DATA state at bit 3 → next edge TX_OUT=1, busy=0. A new DATA_VALID is then accepted normally.
- With UART_TX_HOLD_EN, sending 0xA5 then 0x3C while busy:
  - hold_full=1
  - second start bit immediately follows the 8th stop cycle, with zero idle cycles
  - hold_full clears as the second frame starts
